// File: rtl/output_argmax.sv
// output_argmax
// Finds the highest-scoring class in the neural_net output vector. A start
// pulse in IDLE snapshots every score, then one element per cycle is compared
// against the running best through a single signed comparator. The result is
// registered in DONE, alongside a one-cycle done pulse and a sticky
// result_valid flag.
//
// Optional build macro: ARGMAX_MARGIN_EN adds runner-up tracking and a
// saturating 'margin' output (best - second best).
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        one-cycle request, accepted only in IDLE outside the done pulse
//   scores       N_CLASSES signed DATA_W-bit scores (unpacked array)
//   busy         scan in progress (SCAN or DONE state)
//   done         one-cycle pulse when the result registers are written
//   result_valid result registers hold a completed classification
//   class_idx    index of the maximum score (lowest index wins ties)
//   class_score  value of the maximum score
//   margin       (ARGMAX_MARGIN_EN only) best - second best, saturating
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_SCAN | comparing snapshot[ptr] against the running best
// S_DONE | commit best to the result registers, pulse done
module output_argmax #(
   parameter int N_CLASSES = 10,
   parameter int DATA_W    = 64,
   parameter int IDX_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] scores [N_CLASSES],
   output logic              busy,
   output logic              done,
   output logic              result_valid,
   output logic [IDX_W-1:0]  class_idx,
   output logic [DATA_W-1:0] class_score
`ifdef ARGMAX_MARGIN_EN
   ,
   output logic [DATA_W-1:0] margin
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] snap_q [N_CLASSES];
   logic              snap_en;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic [DATA_W-1:0] best_val_q, best_val_d;
   logic [IDX_W-1:0]  class_idx_q, class_idx_d;
   logic [DATA_W-1:0] class_score_q, class_score_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] cand;
   logic              cand_gt_best;

   assign cand         = snap_q[ptr_q];
   assign cand_gt_best = $signed(cand) > $signed(best_val_q);

`ifdef ARGMAX_MARGIN_EN
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

   logic [DATA_W-1:0] second_q, second_d;
   logic [DATA_W-1:0] margin_q, margin_d;
   logic [DATA_W:0]   gap;

   // Extended by one bit so best - second never wraps; any result above the
   // largest positive DATA_W value saturates.
   assign gap = {best_val_q[DATA_W-1], best_val_q} - {second_q[DATA_W-1], second_q};
`endif

   always_comb begin
      state_d       = state_q;
      snap_en       = 1'b0;
      ptr_d         = ptr_q;
      best_idx_d    = best_idx_q;
      best_val_d    = best_val_q;
      class_idx_d   = class_idx_q;
      class_score_d = class_score_q;
      done_d        = 1'b0;
      valid_d       = valid_q;
`ifdef ARGMAX_MARGIN_EN
      second_d      = second_q;
      margin_d      = margin_q;
`else
      // no runner-up tracking in this build
`endif
      case (state_q)
         S_IDLE: begin
            // done_q high means this cycle is the done pulse: start is ignored
            if (start && !done_q) begin
               snap_en    = 1'b1;
               best_idx_d = '0;
               best_val_d = scores[0];
               ptr_d      = IDX_W'(1);
               valid_d    = 1'b0;
               state_d    = S_SCAN;
`ifdef ARGMAX_MARGIN_EN
               second_d   = MOST_NEG;
`endif
            end
         end
         S_SCAN: begin
            if (cand_gt_best) begin
               best_idx_d = ptr_q;
               best_val_d = cand;
`ifdef ARGMAX_MARGIN_EN
               second_d   = best_val_q;
            end else if ($signed(cand) > $signed(second_q)) begin
               second_d   = cand;
`endif
            end
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == LAST_IDX) state_d = S_DONE;
         end
         S_DONE: begin
            class_idx_d   = best_idx_q;
            class_score_d = best_val_q;
            done_d        = 1'b1;
            valid_d       = 1'b1;
            state_d       = S_IDLE;
`ifdef ARGMAX_MARGIN_EN
            margin_d      = (gap[DATA_W] | gap[DATA_W-1]) ? MAX_POS : gap[DATA_W-1:0];
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         best_idx_q    <= '0;
         best_val_q    <= '0;
         class_idx_q   <= '0;
         class_score_q <= '0;
         done_q        <= 1'b0;
         valid_q       <= 1'b0;
         for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
`ifdef ARGMAX_MARGIN_EN
         second_q      <= '0;
         margin_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         best_idx_q    <= best_idx_d;
         best_val_q    <= best_val_d;
         class_idx_q   <= class_idx_d;
         class_score_q <= class_score_d;
         done_q        <= done_d;
         valid_q       <= valid_d;
         if (snap_en) begin
            for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= scores[i];
         end
`ifdef ARGMAX_MARGIN_EN
         second_q      <= second_d;
         margin_q      <= margin_d;
`endif
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign result_valid = valid_q;
   assign class_idx    = class_idx_q;
   assign class_score  = class_score_q;
`ifdef ARGMAX_MARGIN_EN
   assign margin       = margin_q;
`endif

endmodule

// File: tb/tb_output_argmax.sv
module tb_output_argmax;

   localparam int NC = 10;
   localparam int DW = 64;
   localparam int IW = 4;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;

   typedef logic [DW-1:0] vec_t [NC];

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   vec_t          scores;
   logic          busy, done, result_valid;
   logic [IW-1:0] class_idx;
   logic [DW-1:0] class_score;
`ifdef ARGMAX_MARGIN_EN
   logic [DW-1:0] margin;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   output_argmax #(.N_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .scores(scores),
      .busy(busy), .done(done), .result_valid(result_valid),
      .class_idx(class_idx), .class_score(class_score)
`ifdef ARGMAX_MARGIN_EN
      , .margin(margin)
`endif
   );

   // reference: the maximum value, then the first index that holds it
   function automatic int ref_idx(input vec_t v);
      longint mx = longint'(v[0]);
      for (int i = 1; i < NC; i++) if (longint'(v[i]) > mx) mx = longint'(v[i]);
      for (int i = 0; i < NC; i++) if (longint'(v[i]) == mx) return i;
      return -1;
   endfunction

`ifdef ARGMAX_MARGIN_EN
   // best minus the largest of all other entries, saturated to max positive
   function automatic logic [63:0] ref_margin(input vec_t v);
      int                 bi  = ref_idx(v);
      longint             sec = longint'(MIN64);
      logic signed [64:0] d;
      logic [63:0]        s;
      for (int i = 0; i < NC; i++) if (i != bi && longint'(v[i]) > sec) sec = longint'(v[i]);
      s = 64'(sec);
      d = $signed({v[bi][63], v[bi]}) - $signed({s[63], s});
      if (d > $signed({1'b0, MAX64})) return MAX64;
      return d[63:0];
   endfunction
`endif

   function automatic logic [63:0] rnd_val(input int mode);
      int s;
      case (mode)
         0: return {$urandom, $urandom};
         1: begin
            s = int'($urandom_range(0, 6)) - 3;
            return 64'(longint'(s));
         end
         default: begin
            case ($urandom_range(0, 3))
               0: return MIN64;
               1: return MAX64;
               2: return 64'd0;
               default: return 64'hFFFF_FFFF_FFFF_FFFF;
            endcase
         end
      endcase
   endfunction

   // pulse start for one cycle, then count edges until done (-1 on timeout)
   task automatic run_scan(output int lat);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < NC; i++) scores[i] = '0;
      repeat (2) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
      n_total++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", result_valid); else n_pass++;
      n_total++; if (class_idx !== '0) $display("FAIL reset_idx got %0d exp 0", class_idx); else n_pass++;
      n_total++; if (class_score !== '0) $display("FAIL reset_score got %h exp 0", class_score); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
      n_total++; if (margin !== '0) $display("FAIL reset_margin got %h exp 0", margin); else n_pass++;
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      for (int k = 0; k < NC; k++) scores[k] = 64'(k) << 32;
      run_scan(lat);
      n_total++; if (lat !== 10) $display("FAIL basic_latency got %0d exp 10", lat); else n_pass++;
      n_total++; if (class_idx !== 4'd9) $display("FAIL basic_idx got %0d exp 9", class_idx); else n_pass++;
      n_total++; if (class_score !== 64'h9_0000_0000) $display("FAIL basic_score got %h exp 900000000", class_score); else n_pass++;
      n_total++; if (result_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", result_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got %b exp 0", busy); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
      n_total++; if (margin !== 64'h1_0000_0000) $display("FAIL basic_margin got %h exp 100000000", margin); else n_pass++;
`endif
   endtask

   task automatic test_negative();
      int lat;
      for (int k = 0; k < NC; k++) scores[k] = 64'hFFFF_FFFF_FFFF_FFFB;
      scores[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      scores[6] = MIN64;
      run_scan(lat);
      n_total++; if (lat !== 10) $display("FAIL neg_latency got %0d exp 10", lat); else n_pass++;
      n_total++; if (class_idx !== 4'd3) $display("FAIL neg_idx got %0d exp 3", class_idx); else n_pass++;
      n_total++; if (class_score !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL neg_score got %h exp -1", class_score); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
      n_total++; if (margin !== 64'd4) $display("FAIL neg_margin got %h exp 4", margin); else n_pass++;
`endif
   endtask

   task automatic test_tie();
      int lat;
      for (int k = 0; k < NC; k++) scores[k] = '0;
      scores[2] = 64'd100;
      scores[7] = 64'd100;
      run_scan(lat);
      n_total++; if (class_idx !== 4'd2) $display("FAIL tie_idx got %0d exp 2", class_idx); else n_pass++;
      n_total++; if (class_score !== 64'd100) $display("FAIL tie_score got %0d exp 100", class_score); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
      n_total++; if (margin !== 64'd0) $display("FAIL tie_margin got %0d exp 0", margin); else n_pass++;
`endif
      scores[7] = '0;
      scores[5] = 64'd60;
      run_scan(lat);
      n_total++; if (class_idx !== 4'd2) $display("FAIL gap_idx got %0d exp 2", class_idx); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
      n_total++; if (margin !== 64'd40) $display("FAIL gap_margin got %0d exp 40", margin); else n_pass++;
`endif
   endtask

   task automatic test_random();
      int lat, ei, mode;
      for (int t = 0; t < 24; t++) begin
         mode = t % 3;
         for (int k = 0; k < NC; k++) scores[k] = rnd_val(mode);
         ei = ref_idx(scores);
         run_scan(lat);
         n_total++; if (lat !== 10) $display("FAIL rand%0d_latency got %0d exp 10", t, lat); else n_pass++;
         n_total++; if (class_idx !== IW'(ei)) $display("FAIL rand%0d_idx got %0d exp %0d", t, class_idx, ei); else n_pass++;
         n_total++; if (class_score !== scores[ei]) $display("FAIL rand%0d_score got %h exp %h", t, class_score, scores[ei]); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
         n_total++; if (margin !== ref_margin(scores)) $display("FAIL rand%0d_margin got %h exp %h", t, margin, ref_margin(scores)); else n_pass++;
`endif
      end
   endtask

   task automatic test_snapshot();
      vec_t        orig;
      int          ei, ndone, lat;
      logic [3:0]  got_idx;
      logic [63:0] got_score;
      for (int k = 0; k < NC; k++) scores[k] = 64'($urandom_range(0, 1000));
      orig = scores;
      ei = ref_idx(orig);
      ndone = 0;
      lat = -1;
      got_idx = '0;
      got_score = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 2) scores[9] = MAX64;
         if (c == 4) start = 1'b1;
         if (c == 5) start = 1'b0;
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (lat < 0) begin
               lat = c;
               got_idx = class_idx;
               got_score = class_score;
            end
         end
      end
      n_total++; if (ndone !== 1) $display("FAIL snap_done_count got %0d exp 1", ndone); else n_pass++;
      n_total++; if (lat !== 10) $display("FAIL snap_latency got %0d exp 10", lat); else n_pass++;
      n_total++; if (got_idx !== IW'(ei)) $display("FAIL snap_idx got %0d exp %0d", got_idx, ei); else n_pass++;
      n_total++; if (got_score !== orig[ei]) $display("FAIL snap_score got %h exp %h", got_score, orig[ei]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat, ndone, ei;
      for (int k = 0; k < NC; k++) scores[k] = 64'($urandom_range(0, 1000));
      scores[5] = 64'd5000;
      run_scan(lat);
      n_total++; if (class_idx !== 4'd5) $display("FAIL rmid_pre_idx got %0d exp 5", class_idx); else n_pass++;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (result_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", result_valid); else n_pass++;
      n_total++; if (class_idx !== '0) $display("FAIL rmid_idx got %0d exp 0", class_idx); else n_pass++;
      n_total++; if (class_score !== '0) $display("FAIL rmid_score got %h exp 0", class_score); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_total++; if (ndone !== 0) $display("FAIL rmid_no_done got %0d exp 0", ndone); else n_pass++;
      for (int k = 0; k < NC; k++) scores[k] = rnd_val(0);
      ei = ref_idx(scores);
      run_scan(lat);
      n_total++; if (lat !== 10) $display("FAIL rmid_after_latency got %0d exp 10", lat); else n_pass++;
      n_total++; if (class_idx !== IW'(ei)) $display("FAIL rmid_after_idx got %0d exp %0d", class_idx, ei); else n_pass++;
      n_total++; if (result_valid !== 1'b1) $display("FAIL rmid_after_valid got %b exp 1", result_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat;
      for (int k = 0; k < NC; k++) scores[k] = 64'($urandom_range(0, 1000));
      scores[1] = 64'd1000000;
      run_scan(lat);
      n_total++; if (class_idx !== 4'd1) $display("FAIL b2b_first_idx got %0d exp 1", class_idx); else n_pass++;
      // start raised during the done pulse: must be ignored
      for (int k = 0; k < NC; k++) scores[k] = 64'($urandom_range(0, 1000));
      scores[6] = 64'd2000000;
      start = 1'b1;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done got busy %b exp 0", busy); else n_pass++;
      n_total++; if (result_valid !== 1'b1) $display("FAIL b2b_valid_hold got %b exp 1", result_valid); else n_pass++;
      // still high in the cycle after done: accepted
      @(negedge clk);
      start = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy got %b exp 1", busy); else n_pass++;
      n_total++; if (result_valid !== 1'b0) $display("FAIL b2b_valid_drop got %b exp 0", result_valid); else n_pass++;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_total++; if (lat !== 10) $display("FAIL b2b_latency got %0d exp 10", lat); else n_pass++;
      n_total++; if (class_idx !== 4'd6) $display("FAIL b2b_second_idx got %0d exp 6", class_idx); else n_pass++;
      n_total++; if (class_score !== 64'd2000000) $display("FAIL b2b_second_score got %0d exp 2000000", class_score); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_tie();
      test_random();
      test_snapshot();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
